// File: rtl/upsample_interp_pkg.sv
// rtl/upsample_interp_pkg.sv - shared widths and state encoding for the interpolating upsampler
package upsample_interp_pkg;
  localparam int DEF_IN_W       = 16;
  localparam int DEF_OUT_W      = 12;
  localparam int DEF_LOG2_RATIO = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/upsample_interp_round_sat_reduce.sv
// rtl/upsample_interp_round_sat_reduce.sv - round-half-up width reduction with saturation
module round_sat_reduce #(
  parameter int ACC_W = 20,
  parameter int OUT_W = 12
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] q
);
  localparam int S = ACC_W - OUT_W;
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (S-1);

  logic [ACC_W:0] sum;
  logic [OUT_W:0] r;

  // The extra carry bit turns a would-be wrap into a clamp at full scale.
  always_comb begin
    sum = {1'b0, acc} + HALF;
    r   = sum[ACC_W:S];
    q   = r[OUT_W] ? {OUT_W{1'b1}} : r[OUT_W-1:0];
  end
endmodule

// File: rtl/upsample_interp.sv
// rtl/upsample_interp.sv - linear-interpolating 2^LOG2_RATIO upsampler with one-entry skid buffer
module upsample_interp
  import upsample_interp_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int LOG2_RATIO = DEF_LOG2_RATIO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_sample,
  input  logic             in_valid,
  input  logic             out_tick,
  output logic [OUT_W-1:0] out_sample,
  output logic             out_valid,
  output logic             underrun,
  output logic             overrun
);
  localparam int ACC_W = IN_W + LOG2_RATIO;

  state_t                  state;
  logic [IN_W-1:0]         cur;
  logic [IN_W-1:0]         pend;
  logic                    pend_full;
  logic [ACC_W-1:0]        acc;
  logic signed [IN_W:0]    delta;
  logic [LOG2_RATIO-1:0]   phase;

  logic                    seg_end;
  logic [IN_W-1:0]         nxt;
  logic [ACC_W-1:0]        delta_ext;
  logic [OUT_W-1:0]        rs_q;

  round_sat_reduce #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_rsr (
    .acc (acc),
    .q   (rs_q)
  );

  // Next segment target: buffered sample wins, then a same-cycle bypass, else hold.
  always_comb begin
    seg_end   = out_tick && (&phase);
    nxt       = cur;
    if (pend_full)
      nxt = pend;
    else if (in_valid)
      nxt = in_sample;
    delta_ext = {{(ACC_W-IN_W-1){delta[IN_W]}}, delta};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      acc        <= '0;
      delta      <= '0;
      phase      <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur   <= in_sample;
            acc   <= {in_sample, {LOG2_RATIO{1'b0}}};
            delta <= '0;
            phase <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (out_tick) begin
            out_sample <= rs_q;
            out_valid  <= 1'b1;
            phase      <= phase + LOG2_RATIO'(1);
            if (seg_end) begin
              // Reload from cur rather than trusting the accumulated ramp.
              acc   <= {cur, {LOG2_RATIO{1'b0}}};
              delta <= $signed({1'b0, nxt}) - $signed({1'b0, cur});
              cur   <= nxt;
              if (pend_full) begin
                pend_full <= in_valid;
                if (in_valid)
                  pend <= in_sample;
              end else if (!in_valid) begin
                underrun <= 1'b1;
              end
            end else begin
              acc <= acc + delta_ext;
            end
          end
          if (in_valid && !seg_end) begin
            if (pend_full)
              overrun <= 1'b1;
            pend      <= in_sample;
            pend_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upsample_interp.sv
// tb/tb_upsample_interp.sv - directed self-checking bench for upsample_interp
module tb_upsample_interp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_sample = '0;
  logic        in_valid = 1'b0;
  logic        out_tick = 1'b0;
  logic [11:0] out_sample;
  logic        out_valid;
  logic        underrun;
  logic        overrun;

  int n_vec = 0;
  int n_bad = 0;

  upsample_interp dut (
    .clk        (clk),
    .reset      (reset),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .out_tick   (out_tick),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [15:0] s, input logic eov);
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    chk("feed_overrun", {31'b0, overrun}, {31'b0, eov});
  endtask

  // One output request, optionally with a coincident input, then three quiet clocks.
  task automatic tk(input logic [11:0] es, input logic eur, input logic eov,
                    input logic v, input logic [15:0] s);
    out_tick  = 1'b1;
    in_valid  = v;
    in_sample = s;
    @(posedge clk); #1;
    out_tick  = 1'b0;
    in_valid  = 1'b0;
    chk("tick_valid", {31'b0, out_valid}, 32'd1);
    chk("tick_sample", {20'b0, out_sample}, {20'b0, es});
    chk("tick_underrun", {31'b0, underrun}, {31'b0, eur});
    chk("tick_overrun", {31'b0, overrun}, {31'b0, eov});
    @(posedge clk); #1;
    chk("valid_pulse", {31'b0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_sample", {20'b0, out_sample}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Ticks before any input are ignored.
    out_tick = 1'b1;
    @(posedge clk); #1;
    out_tick = 1'b0;
    chk("idle_tick_valid", {31'b0, out_valid}, 32'd0);

    // Ramp 0x1000 -> 0x2000
    feed(16'h1000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) feed(16'h2000, 1'b0);
      tk(12'h100, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    for (int i = 0; i < 16; i++)
      tk(12'(12'h100 + 16 * i), (i == 15), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++)
      tk(12'h200, 1'b0, 1'b0, 1'b0, 16'h0);

    // Saturation and rounding
    do_reset();
    feed(16'hFFFF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) feed(16'hFFFF, 1'b0);
      tk(12'hFFF, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    for (int i = 0; i < 4; i++)
      tk(12'hFFF, 1'b0, 1'b0, 1'b0, 16'h0);
    do_reset();
    feed(16'h0007, 1'b0);
    tk(12'h000, 1'b0, 1'b0, 1'b0, 16'h0);
    do_reset();
    feed(16'h0008, 1'b0);
    tk(12'h001, 1'b0, 1'b0, 1'b0, 16'h0);

    // Underrun: single input, 40 ticks
    do_reset();
    feed(16'h1000, 1'b0);
    for (int i = 1; i <= 40; i++)
      tk(12'h100, (i == 16 || i == 32), 1'b0, 1'b0, 16'h0);

    // Overrun: 0x2000 dropped in favour of 0x3000
    do_reset();
    feed(16'h1000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) feed(16'h2000, 1'b0);
      if (i == 5) feed(16'h3000, 1'b1);
      tk(12'h100, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    for (int i = 0; i < 8; i++)
      tk(12'(12'h100 + 32 * i), 1'b0, 1'b0, 1'b0, 16'h0);

    // Async reset between edges, mid-ramp
    reset = 1'b1;
    #1;
    chk("async_rst_sample", {20'b0, out_sample}, 32'd0);
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_tick = 1'b1;
    @(posedge clk); #1;
    out_tick = 1'b0;
    chk("post_rst_tick_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_sample", {20'b0, out_sample}, 32'd0);

    // Coincidence at segment end: pend empty (bypass), then pend full (refill)
    feed(16'h1000, 1'b0);
    for (int i = 0; i < 15; i++)
      tk(12'h100, 1'b0, 1'b0, 1'b0, 16'h0);
    tk(12'h100, 1'b0, 1'b0, 1'b1, 16'h2000);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) feed(16'h3000, 1'b0);
      tk(12'(12'h100 + 16 * i), 1'b0, 1'b0, 1'b0, 16'h0);
    end
    tk(12'h1F0, 1'b0, 1'b0, 1'b1, 16'h4000);
    for (int i = 0; i < 16; i++)
      tk(12'(12'h200 + 16 * i), 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++)
      tk(12'(12'h300 + 16 * i), 1'b0, 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
